// File: rtl/bambu_slave_pkg.sv
// Shared types and constants for the Bambu slave-port read-back engine.
// The slave port carries 16-bit words at 14-bit byte addresses.
package bambu_slave_pkg;

    localparam int SLAVE_DATA_W = 16;
    localparam int SLAVE_ADDR_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FINISH = 3'd4
    } rb_state_e;

    // S_data_ram_size carries the access width in bits.
    function automatic logic [7:0] size_enc(input int unsigned width_bits);
        return 8'(width_bits);
    endfunction

    localparam logic [7:0] SLAVE_SIZE_ENC = size_enc(SLAVE_DATA_W);

endpackage

// File: rtl/slave_rd_timer.sv
// Per-read response timer: counts WAIT cycles and flags when the
// current cycle is the last one allowed before giving up on the slave.
module slave_rd_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts WAIT cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1.
    assign expired = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/bambu_slave_readback.sv
// Reads a block of words out of a Bambu accelerator through its slave memory
// port and presents them one by one on a valid/ready stream.
//
//  state  | meaning
//  IDLE   | waiting for start; outputs quiet
//  ISSUE  | one-cycle read strobe at the current address
//  WAIT   | strobe dropped, waiting for DataRdy or timeout
//  HOLD   | word presented on the stream until accepted
//  FINISH | one-cycle done pulse, then back to IDLE
module bambu_slave_readback
    import bambu_slave_pkg::*;
#(
    parameter int ADDR_W  = SLAVE_ADDR_W,
    parameter int DATA_W  = SLAVE_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [1:0]        S_oe_ram,
    output logic [1:0]        S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [DATA_W-1:0] S_Wdata_ram,
    output logic [7:0]        S_data_ram_size,
    input  logic [DATA_W-1:0] Sout_Rdata_ram,
    input  logic [1:0]        Sout_DataRdy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);
    localparam logic [7:0]        SIZE_ENC = size_enc(DATA_W);

    rb_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              error_q, error_d;
    logic [1:0]        oe_q, oe_d;
    logic [7:0]        size_q, size_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic rdy;
    logic accept_start;
    logic handshake;
    logic capture;
    logic timer_expired;
    logic timed_out;

    assign rdy          = Sout_DataRdy[0];
    assign accept_start = (state_q == ST_IDLE) && start;
    assign handshake    = (state_q == ST_HOLD) && out_ready;
    assign capture      = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && rdy;
    assign timed_out    = (state_q == ST_WAIT) && !rdy && timer_expired;

    slave_rd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q != ST_WAIT),
        .enable  (state_q == ST_WAIT),
        .expired (timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (word_count == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = rdy ? ST_HOLD : ST_WAIT;
            end
            ST_WAIT: begin
                // A word arriving on the timeout cycle is still delivered.
                if (rdy) begin
                    state_d = ST_HOLD;
                end else if (timer_expired) begin
                    state_d = ST_FINISH;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = (rem_q == ADDR_W'(1)) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        error_d = error_q;
        if (accept_start) begin
            addr_d  = base_addr;
            rem_d   = word_count;
            error_d = 1'b0;
        end
        if (handshake) begin
            addr_d = addr_q + STRIDE;
            rem_d  = rem_q - 1'b1;
        end
        if (capture) begin
            data_d = Sout_Rdata_ram;
        end
        if (timed_out) begin
            error_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they land in flops.
    always_comb begin
        oe_d    = (state_d == ST_ISSUE) ? 2'b01 : 2'b00;
        size_d  = (state_d == ST_ISSUE) ? SIZE_ENC : 8'd0;
        valid_d = (state_d == ST_HOLD);
        last_d  = (state_d == ST_HOLD) && (rem_d == ADDR_W'(1));
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            oe_q    <= 2'b00;
            size_q  <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            error_q <= error_d;
            oe_q    <= oe_d;
            size_q  <= size_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign S_oe_ram        = oe_q;
    assign S_we_ram        = 2'b00;
    assign S_addr_ram      = addr_q;
    assign S_Wdata_ram     = '0;
    assign S_data_ram_size = size_q;
    assign out_valid       = valid_q;
    assign out_data        = data_q;
    assign out_last        = last_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

    logic unused_rdy_hi;
    assign unused_rdy_hi = Sout_DataRdy[1];

endmodule
